// File: rtl/vga_pkg.sv
// Shared 640x480@60 Hz VGA timing constants, colour widths and a small range helper.
// The frame painters import this too, so they agree with the timing generator on geometry.
package vga_pkg;

    // System clocks per pixel tick (100 MHz system clock -> 25 MHz pixel rate)
    localparam int CLK_DIV = 4;

    // Horizontal timing, in pixels
    localparam int H_VIS   = 640;
    localparam int H_FP    = 16;
    localparam int H_SYNC  = 96;
    localparam int H_BP    = 48;
    localparam int H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;

    // Vertical timing, in lines
    localparam int V_VIS   = 480;
    localparam int V_FP    = 10;
    localparam int V_SYNC  = 2;
    localparam int V_BP    = 33;
    localparam int V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;

    // Inclusive sync windows, in scan-counter units
    localparam int H_SYNC_START = H_VIS + H_FP;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
    localparam int V_SYNC_START = V_VIS + V_FP;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;

    // Scan counter and colour channel widths
    localparam int CNT_W   = 10;
    localparam int RED_W   = 3;
    localparam int GREEN_W = 3;
    localparam int BLUE_W  = 2;

    // Unsigned inclusive range test, used for the sync windows
    function automatic logic in_range(input int unsigned v,
                                      input int unsigned lo,
                                      input int unsigned hi);
        return (v >= lo) && (v <= hi);
    endfunction

endpackage

// File: rtl/vga_timing_gen_pix_clk_en.sv
// Pixel-rate enable: a free-running divider that is high for one system clock
// out of every CLK_DIV, on the last count of the divider.
module pix_clk_en #(
    parameter int CLK_DIV = 4
) (
    input  logic i_clk,
    input  logic i_rst,
    output logic o_pix_en
);

    localparam int DIV_W = $clog2(CLK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);

    if (CLK_DIV < 2) begin : g_bad_div
        $error("pix_clk_en: CLK_DIV must be at least 2");
    end

    logic [DIV_W-1:0] r_div;
    logic             w_div_last;

    assign w_div_last = (r_div == DIV_LAST);

    // Divider counts 0..CLK_DIV-1 and wraps
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_div <= '0;
        end else if (w_div_last) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    // Enable is decoded straight from the count so it is already low in reset
    assign o_pix_en = w_div_last;

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: scan counters for the painters, plus a registered pin
// stage so colour, hsync and vsync all change on the same pixel tick.
// The pins lag hc/vc by exactly one pixel tick.
module vga_timing_gen #(
    parameter int CLK_DIV = vga_pkg::CLK_DIV,
    parameter int H_VIS   = vga_pkg::H_VIS,
    parameter int H_FP    = vga_pkg::H_FP,
    parameter int H_SYNC  = vga_pkg::H_SYNC,
    parameter int H_BP    = vga_pkg::H_BP,
    parameter int V_VIS   = vga_pkg::V_VIS,
    parameter int V_FP    = vga_pkg::V_FP,
    parameter int V_SYNC  = vga_pkg::V_SYNC,
    parameter int V_BP    = vga_pkg::V_BP
) (
    input  logic                        clk,
    input  logic                        rst,
    output logic [vga_pkg::CNT_W-1:0]   hc,
    output logic [vga_pkg::CNT_W-1:0]   vc,
    output logic                        pix_en,
    output logic                        frame_start,
    input  logic [vga_pkg::RED_W-1:0]   red_in,
    input  logic [vga_pkg::GREEN_W-1:0] green_in,
    input  logic [vga_pkg::BLUE_W-1:0]  blue_in,
    output logic [vga_pkg::RED_W-1:0]   red,
    output logic [vga_pkg::GREEN_W-1:0] green,
    output logic [vga_pkg::BLUE_W-1:0]  blue,
    output logic                        hsync,
    output logic                        vsync
);

    import vga_pkg::*;

    // Geometry derived from this instance's parameters
    localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_VIS + H_FP;
    localparam int HS_END   = HS_START + H_SYNC - 1;
    localparam int VS_START = V_VIS + V_FP;
    localparam int VS_END   = VS_START + V_SYNC - 1;

    localparam logic [CNT_W-1:0] H_LAST  = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST  = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_VIS_C = CNT_W'(H_VIS);
    localparam logic [CNT_W-1:0] V_VIS_C = CNT_W'(V_VIS);

    if ((H_TOT > (1 << CNT_W)) || (V_TOT > (1 << CNT_W))) begin : g_bad_totals
        $error("vga_timing_gen: line or frame total does not fit the scan counters");
    end

    logic                 w_pix_en;
    logic [CNT_W-1:0]     r_hc;
    logic [CNT_W-1:0]     r_vc;
    logic                 w_h_last;
    logic                 w_v_last;
    logic                 w_visible;
    logic                 w_hs_active;
    logic                 w_vs_active;
    logic [RED_W-1:0]     r_red;
    logic [GREEN_W-1:0]   r_green;
    logic [BLUE_W-1:0]    r_blue;
    logic                 r_hsync;
    logic                 r_vsync;

    pix_clk_en #(
        .CLK_DIV (CLK_DIV)
    ) u_pix_clk_en (
        .i_clk    (clk),
        .i_rst    (rst),
        .o_pix_en (w_pix_en)
    );

    assign w_h_last = (r_hc == H_LAST);
    assign w_v_last = (r_vc == V_LAST);

    // Scan counters advance only on pixel ticks; vc steps at the end of each line
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hc <= '0;
            r_vc <= '0;
        end else if (w_pix_en) begin
            if (w_h_last) begin
                r_hc <= '0;
                if (w_v_last) begin
                    r_vc <= '0;
                end else begin
                    r_vc <= r_vc + 1'b1;
                end
            end else begin
                r_hc <= r_hc + 1'b1;
            end
        end
    end

    // Decode of the current (pre-increment) scan position
    assign w_visible   = (r_hc < H_VIS_C) && (r_vc < V_VIS_C);
    assign w_hs_active = in_range(32'(r_hc), HS_START, HS_END);
    assign w_vs_active = in_range(32'(r_vc), VS_START, VS_END);

    // Pin stage: painter colour is sampled only on the tick, blanked off-screen
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_red   <= '0;
            r_green <= '0;
            r_blue  <= '0;
            r_hsync <= 1'b1;
            r_vsync <= 1'b1;
        end else if (w_pix_en) begin
            r_red   <= w_visible ? red_in   : '0;
            r_green <= w_visible ? green_in : '0;
            r_blue  <= w_visible ? blue_in  : '0;
            r_hsync <= ~w_hs_active;
            r_vsync <= ~w_vs_active;
        end
    end

    assign hc          = r_hc;
    assign vc          = r_vc;
    assign pix_en      = w_pix_en;
    assign frame_start = w_pix_en & w_h_last & w_v_last;
    assign red         = r_red;
    assign green       = r_green;
    assign blue        = r_blue;
    assign hsync       = r_hsync;
    assign vsync       = r_vsync;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen. Horizontal geometry is the real 800-pixel line; the
// frame is shortened to 9 lines (vsync on lines 5..6) so two frames fit the run.
module tb_vga_timing_gen;

  localparam int DIV = 4;
  localparam int HT  = 800;
  localparam int VT  = 9;
  localparam int FRAME_CLKS = HT * VT * DIV;

  logic       clk;
  logic       rst;
  logic [9:0] hc;
  logic [9:0] vc;
  logic       pix_en;
  logic       frame_start;
  logic [2:0] red_in;
  logic [2:0] green_in;
  logic [1:0] blue_in;
  logic [2:0] red;
  logic [2:0] green;
  logic [1:0] blue;
  logic       hsync;
  logic       vsync;

  logic [2:0] drv_r;
  logic [2:0] drv_g;
  logic [1:0] drv_b;
  logic       painter_mode;
  logic       meas_on;
  logic       lit_on;

  int tests = 0;
  int fails = 0;

  vga_timing_gen #(
    .CLK_DIV (DIV),
    .H_VIS   (640),
    .H_FP    (16),
    .H_SYNC  (96),
    .H_BP    (48),
    .V_VIS   (4),
    .V_FP    (1),
    .V_SYNC  (2),
    .V_BP    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .hc          (hc),
    .vc          (vc),
    .pix_en      (pix_en),
    .frame_start (frame_start),
    .red_in      (red_in),
    .green_in    (green_in),
    .blue_in     (blue_in),
    .red         (red),
    .green       (green),
    .blue        (blue),
    .hsync       (hsync),
    .vsync       (vsync)
  );

  // Painter: either echoes hc[2:0] on red, or returns bench-driven colour
  assign red_in   = painter_mode ? hc[2:0] : drv_r;
  assign green_in = drv_g;
  assign blue_in  = drv_b;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // t = system clock edges since reset release; everything follows from it.
  int         t = 0;
  logic [2:0] exp_r = '0;
  logic [2:0] exp_g = '0;
  logic [1:0] exp_b = '0;
  logic       exp_hs = 1'b1;
  logic       exp_vs = 1'b1;
  logic       align_valid = 1'b0;
  logic [2:0] exp_align = '0;

  logic       pend_valid = 1'b0;
  logic [2:0] pend_r;
  logic [2:0] pend_g;
  logic [1:0] pend_b;
  logic       pend_hs;
  logic       pend_vs;
  logic       pend_align_valid;
  logic [2:0] pend_align;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      t           <= 0;
      exp_r       <= '0;
      exp_g       <= '0;
      exp_b       <= '0;
      exp_hs      <= 1'b1;
      exp_vs      <= 1'b1;
      align_valid <= 1'b0;
    end else begin
      t <= t + 1;
      if (pend_valid) begin
        exp_r       <= pend_r;
        exp_g       <= pend_g;
        exp_b       <= pend_b;
        exp_hs      <= pend_hs;
        exp_vs      <= pend_vs;
        align_valid <= pend_align_valid;
        exp_align   <= pend_align;
      end
    end
  end

  // ---------------- compare process (every clock, at negedge) ----------------
  always @(negedge clk) begin
    int   n;
    int   h;
    int   v;
    logic pe;
    logic fs;
    logic vis;
    if (rst) begin
      chk("reset_state", {hc, vc, pix_en, frame_start, red, green, blue, hsync, vsync},
          {10'd0, 10'd0, 1'b0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1, 1'b1});
      pend_valid <= 1'b0;
    end else begin
      n   = t / DIV;
      h   = n % HT;
      v   = (n / HT) % VT;
      pe  = (t % DIV) == DIV - 1;
      fs  = pe && ((n % (HT * VT)) == HT * VT - 1);
      chk("cycle", {hc, vc, pix_en, frame_start, red, green, blue, hsync, vsync},
          {10'(h), 10'(v), pe, fs, exp_r, exp_g, exp_b, exp_hs, exp_vs});
      if (align_valid)
        chk("align_red_prev_hc", {29'd0, red}, {29'd0, exp_align});
      vis = (h < 640) && (v < 4);
      pend_valid       <= pe;
      pend_r           <= vis ? red_in   : 3'd0;
      pend_g           <= vis ? green_in : 3'd0;
      pend_b           <= vis ? blue_in  : 2'd0;
      pend_hs          <= !((h >= 656) && (h <= 751));
      pend_vs          <= !((v >= 5) && (v <= 6));
      pend_align_valid <= vis && painter_mode;
      pend_align       <= 3'(h);

      // Hand-computed pins for the model itself
      if (lit_on) begin
        if (t == 3)     chk("first_pix_en", {21'd0, pix_en, hc}, {21'd0, 1'b1, 10'd0});
        if (t == 4)     chk("hc_after_first_tick", {21'd0, pix_en, hc}, {21'd0, 1'b0, 10'd1});
        if (t == 2560)  chk("last_visible_col", {24'd0, red, green, blue}, 32'h0000_00FF);
        if (t == 2564)  chk("first_blank_col", {24'd0, red, green, blue}, 32'd0);
        if (t == 12804) chk("first_blank_row", {24'd0, red, green, blue}, 32'd0);
        if (t == FRAME_CLKS - 1)
          chk("wrap_before", {11'd0, hc, vc, frame_start}, {11'd0, 10'd799, 10'd8, 1'b1});
        if (t == FRAME_CLKS)
          chk("wrap_after", {11'd0, hc, vc, frame_start}, {11'd0, 10'd0, 10'd0, 1'b0});
      end
    end
  end

  // ---------------- edge monitor for line/frame timing ----------------
  int   hs_fall0 = -1, hs_fall1 = -1, hs_rise0 = -1;
  int   vs_fall0 = -1, vs_fall1 = -1, vs_rise0 = -1;
  int   fs_t0 = -1, fs_t1 = -1, fs_run = 0, fs_maxrun = 0;
  logic prev_hs = 1'b1, prev_vs = 1'b1, prev_fs = 1'b0;

  always @(negedge clk) begin
    if (meas_on && !rst) begin
      if (prev_hs && !hsync) begin
        if (hs_fall0 < 0) hs_fall0 = t;
        else if (hs_fall1 < 0) hs_fall1 = t;
      end
      if (!prev_hs && hsync && hs_fall0 >= 0 && hs_rise0 < 0) hs_rise0 = t;
      if (prev_vs && !vsync) begin
        if (vs_fall0 < 0) vs_fall0 = t;
        else if (vs_fall1 < 0) vs_fall1 = t;
      end
      if (!prev_vs && vsync && vs_fall0 >= 0 && vs_rise0 < 0) vs_rise0 = t;
      if (frame_start && !prev_fs) begin
        if (fs_t0 < 0) fs_t0 = t;
        else if (fs_t1 < 0) fs_t1 = t;
      end
      fs_run = frame_start ? fs_run + 1 : 0;
      if (fs_run > fs_maxrun) fs_maxrun = fs_run;
      prev_hs = hsync;
      prev_vs = vsync;
      prev_fs = frame_start;
    end
  end

  // ---------------- driver tasks ----------------
  // Line 0,3,6: full-scale constant; 1,4,7: random; 2,5,8: hc echo painter
  task automatic drive_inputs();
    int mode;
    mode = (t / (HT * DIV)) % 3;
    painter_mode = (mode == 2);
    if (mode == 0) begin
      drv_r = 3'd7;
      drv_g = 3'd7;
      drv_b = 2'd3;
    end else if ($urandom_range(1, 0) == 1) begin
      drv_r = 3'($urandom_range(7, 0));
      drv_g = 3'($urandom_range(7, 0));
      drv_b = 2'($urandom_range(3, 0));
    end
  endtask

  task automatic run(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #2;
      drive_inputs();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b0;
    drv_r = '0;
    drv_g = '0;
    drv_b = '0;
    painter_mode = 1'b0;
    meas_on = 1'b0;
    lit_on = 1'b0;
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Run into the hsync pulse of the first line, then reset mid-pulse
    run(2700);
    chk("in_hsync_pulse", {31'd0, hsync}, 32'd0);
    rst = 1'b1;
    #1;
    chk("mid_reset_pins", {2'd0, hc, vc, hsync, vsync, red, green, blue},
        {2'd0, 10'd0, 10'd0, 1'b1, 1'b1, 3'd0, 3'd0, 2'd0});
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;
    meas_on = 1'b1;
    lit_on = 1'b1;

    // Two full (shortened) frames plus margin
    run(2 * FRAME_CLKS + 200);

    chk("hsync_first_fall", hs_fall0, 32'd2628);
    chk("hsync_low_width", hs_rise0 - hs_fall0, 32'd384);
    chk("line_period", hs_fall1 - hs_fall0, 32'd3200);
    chk("vsync_first_fall", vs_fall0, 32'd16004);
    chk("vsync_low_width", vs_rise0 - vs_fall0, 32'd6400);
    chk("vsync_period", vs_fall1 - vs_fall0, 32'(FRAME_CLKS));
    chk("frame_start_first", fs_t0, 32'(FRAME_CLKS - 1));
    chk("frame_start_period", fs_t1 - fs_t0, 32'(FRAME_CLKS));
    chk("frame_start_width", fs_maxrun, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
